// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic [3:0] state;
    logic       retire;
    logic       illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, iord, reg_write,
               mem_to_reg, pc_src, alu_src_a, alu_src_b, alu_op, imm_src,
               state, retire, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, iord, reg_write,
               mem_to_reg, pc_src, alu_src_a, alu_src_b, alu_op, imm_src,
               state, retire, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32-subset control FSM: fetch/decode, load/store, R/I ALU ops, beq.
// Control outputs are combinational from state and inputs, forced to 0 while rst_n is low.
module multicycle_controller (
    input  logic                           clk,
    input  logic                           rst_n,
    multicycle_controller_if.master        bus
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_ILLEGAL   = 4'd10
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_src;
        logic       retire;
        logic       illegal;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_s;
    ctrl_t  ctrl_gated_s;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d = S_FETCH;
        ctrl_s  = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.alu_src_b = 2'b10;
                if (bus.mem_ready) begin
                    ctrl_s.ir_write = 1'b1;
                    ctrl_s.pc_write = 1'b1;
                    state_d         = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ctrl_s.alu_src_a = 2'b01;
                ctrl_s.alu_src_b = 2'b01;
                ctrl_s.imm_src   = 2'b10;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                ctrl_s.alu_src_a = 2'b10;
                ctrl_s.alu_src_b = 2'b01;
                if (bus.opcode == OP_STORE) begin
                    ctrl_s.imm_src = 2'b01;
                    state_d        = S_MEM_WRITE;
                end else begin
                    ctrl_s.imm_src = 2'b00;
                    state_d        = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.iord     = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end else begin
                    state_d = S_MEM_READ;
                end
            end
            S_MEM_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.retire     = 1'b1;
                state_d           = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.iord      = 1'b1;
                if (bus.mem_ready) begin
                    ctrl_s.retire = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    state_d = S_MEM_WRITE;
                end
            end
            S_EXEC_R: begin
                ctrl_s.alu_src_a = 2'b10;
                ctrl_s.alu_op    = 2'b10;
                state_d          = S_ALU_WB;
            end
            S_EXEC_I: begin
                ctrl_s.alu_src_a = 2'b10;
                ctrl_s.alu_src_b = 2'b01;
                ctrl_s.alu_op    = 2'b11;
                state_d          = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.retire    = 1'b1;
                state_d          = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_s.alu_src_a = 2'b10;
                ctrl_s.alu_op    = 2'b01;
                ctrl_s.pc_src    = 1'b1;
                ctrl_s.pc_write  = bus.zero;
                ctrl_s.retire    = 1'b1;
                state_d          = S_FETCH;
            end
            S_ILLEGAL: begin
                // Parked until reset; no further fetch.
                ctrl_s.illegal = 1'b1;
                state_d        = S_ILLEGAL;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Strobes are suppressed for the whole time reset is held.
    always_comb begin
        if (rst_n) begin
            ctrl_gated_s = ctrl_s;
        end else begin
            ctrl_gated_s = '0;
        end
    end

    assign bus.pc_write   = ctrl_gated_s.pc_write;
    assign bus.ir_write   = ctrl_gated_s.ir_write;
    assign bus.mem_read   = ctrl_gated_s.mem_read;
    assign bus.mem_write  = ctrl_gated_s.mem_write;
    assign bus.iord       = ctrl_gated_s.iord;
    assign bus.reg_write  = ctrl_gated_s.reg_write;
    assign bus.mem_to_reg = ctrl_gated_s.mem_to_reg;
    assign bus.pc_src     = ctrl_gated_s.pc_src;
    assign bus.retire     = ctrl_gated_s.retire;
    assign bus.illegal    = ctrl_gated_s.illegal;
    assign bus.alu_src_a  = ctrl_gated_s.alu_src_a;
    assign bus.alu_src_b  = ctrl_gated_s.alu_src_b;
    assign bus.alu_op     = ctrl_gated_s.alu_op;
    assign bus.imm_src    = ctrl_gated_s.imm_src;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: each cycle checks state,
// the strobe vector and the mux-select vector against hand-computed values.
module tb_multicycle_controller;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg, pc_src, retire, illegal}
    logic [9:0] strobes_s;
    // {alu_src_a, alu_src_b, alu_op, imm_src}
    logic [7:0] mux_s;
    assign strobes_s = {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.iord,
                        bus.reg_write, bus.mem_to_reg, bus.pc_src, bus.retire, bus.illegal};
    assign mux_s     = {bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src};

    localparam logic [9:0] SB_NONE    = 10'b0000000000;
    localparam logic [9:0] SB_FETCH_R = 10'b1110000000;
    localparam logic [9:0] SB_FETCH_W = 10'b0010000000;
    localparam logic [9:0] SB_MEMRD   = 10'b0010100000;
    localparam logic [9:0] SB_MEMWB   = 10'b0000011010;
    localparam logic [9:0] SB_MEMWR_R = 10'b0001100010;
    localparam logic [9:0] SB_MEMWR_W = 10'b0001100000;
    localparam logic [9:0] SB_ALUWB   = 10'b0000010010;
    localparam logic [9:0] SB_BR_T    = 10'b1000000110;
    localparam logic [9:0] SB_BR_NT   = 10'b0000000110;
    localparam logic [9:0] SB_ILL     = 10'b0000000001;

    localparam logic [7:0] MX_NONE   = 8'b00000000;
    localparam logic [7:0] MX_FETCH  = 8'b00100000;
    localparam logic [7:0] MX_DECODE = 8'b01010010;
    localparam logic [7:0] MX_ADDR_L = 8'b10010000;
    localparam logic [7:0] MX_ADDR_S = 8'b10010001;
    localparam logic [7:0] MX_EXEC_R = 8'b10001000;
    localparam logic [7:0] MX_EXEC_I = 8'b10011100;
    localparam logic [7:0] MX_BRANCH = 8'b10000100;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Inputs were applied at posedge+1; check outputs, then move to the next posedge+1.
    task automatic step(input string tag, input logic [3:0] st, input logic [9:0] sb,
                        input logic [7:0] mx);
        #1;
        chk({tag, ".state"}, {12'd0, bus.state}, {12'd0, st});
        chk({tag, ".strobes"}, {6'd0, strobes_s}, {6'd0, sb});
        chk({tag, ".mux"}, {8'd0, mux_s}, {8'd0, mx});
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.opcode    = 7'b0110011;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step("rst_hold", 4'd0, SB_NONE, MX_NONE);
        rst_n = 1'b1;

        // R-type, memory always ready
        step("r_fetch",  4'd0, SB_FETCH_R, MX_FETCH);
        step("r_decode", 4'd1, SB_NONE,    MX_DECODE);
        step("r_exec",   4'd6, SB_NONE,    MX_EXEC_R);
        step("r_wb",     4'd8, SB_ALUWB,   MX_NONE);

        // I-type
        bus.opcode = 7'b0010011;
        step("i_fetch",  4'd0, SB_FETCH_R, MX_FETCH);
        step("i_decode", 4'd1, SB_NONE,    MX_DECODE);
        step("i_exec",   4'd7, SB_NONE,    MX_EXEC_I);
        step("i_wb",     4'd8, SB_ALUWB,   MX_NONE);

        // Load with two wait cycles in MEM_READ; fetch itself stalls one cycle first
        bus.opcode    = 7'b0000011;
        bus.mem_ready = 1'b0;
        step("lw_fetch_wait", 4'd0, SB_FETCH_W, MX_FETCH);
        bus.mem_ready = 1'b1;
        step("lw_fetch",  4'd0, SB_FETCH_R, MX_FETCH);
        step("lw_decode", 4'd1, SB_NONE,    MX_DECODE);
        step("lw_addr",   4'd2, SB_NONE,    MX_ADDR_L);
        bus.mem_ready = 1'b0;
        step("lw_rd_w1",  4'd3, SB_MEMRD,   MX_NONE);
        step("lw_rd_w2",  4'd3, SB_MEMRD,   MX_NONE);
        bus.mem_ready = 1'b1;
        step("lw_rd",     4'd3, SB_MEMRD,   MX_NONE);
        step("lw_wb",     4'd4, SB_MEMWB,   MX_NONE);

        // Store, memory ready
        bus.opcode = 7'b0100011;
        step("sw_fetch",  4'd0, SB_FETCH_R, MX_FETCH);
        step("sw_decode", 4'd1, SB_NONE,    MX_DECODE);
        step("sw_addr",   4'd2, SB_NONE,    MX_ADDR_S);
        step("sw_wr",     4'd5, SB_MEMWR_R, MX_NONE);

        // Branch taken then not taken
        bus.opcode = 7'b1100011;
        bus.zero   = 1'b1;
        step("beq_t_fetch",  4'd0, SB_FETCH_R, MX_FETCH);
        step("beq_t_decode", 4'd1, SB_NONE,    MX_DECODE);
        step("beq_t_br",     4'd9, SB_BR_T,    MX_BRANCH);
        bus.zero = 1'b0;
        step("beq_n_fetch",  4'd0, SB_FETCH_R, MX_FETCH);
        step("beq_n_decode", 4'd1, SB_NONE,    MX_DECODE);
        step("beq_n_br",     4'd9, SB_BR_NT,   MX_BRANCH);

        // Reset during a waiting store abandons the write
        bus.opcode = 7'b0100011;
        step("swr_fetch",  4'd0, SB_FETCH_R, MX_FETCH);
        step("swr_decode", 4'd1, SB_NONE,    MX_DECODE);
        step("swr_addr",   4'd2, SB_NONE,    MX_ADDR_S);
        bus.mem_ready = 1'b0;
        step("swr_wait",   4'd5, SB_MEMWR_W, MX_NONE);
        rst_n = 1'b0;
        step("swr_rst_gated", 4'd5, SB_NONE, MX_NONE);
        step("swr_rst_fetch", 4'd0, SB_NONE, MX_NONE);
        rst_n         = 1'b1;
        bus.mem_ready = 1'b1;
        step("swr_refetch", 4'd0, SB_FETCH_R, MX_FETCH);

        // Illegal opcode parks the controller until reset
        bus.opcode = 7'b1111111;
        step("ill_decode", 4'd1, SB_NONE, MX_DECODE);
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = i[0];
            step("ill_hold", 4'd10, SB_ILL, MX_NONE);
        end
        rst_n = 1'b0;
        step("ill_rst_gated", 4'd10, SB_NONE, MX_NONE);
        rst_n         = 1'b1;
        bus.opcode    = 7'b0110011;
        bus.mem_ready = 1'b1;
        step("ill_after_rst", 4'd0, SB_FETCH_R, MX_FETCH);
        step("post_decode",   4'd1, SB_NONE,    MX_DECODE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: opcode  in  7  instruction[6:0] from instruction register, stable between ir_write pulses.
REQ-004 SHALL have ports: zero  in  1  ALU zero flag; mem_ready  in  1  memory completes current access this cycle.
REQ-005 SHALL have ports: pc_write, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg, pc_src  out  1 each; iord 0=PC address, 1=ALUOut address; pc_src 0=ALU result, 1=ALUOut.
REQ-006 SHALL have ports: alu_src_a  out  2  (00 PC, 01 old PC, 10 rs1); alu_src_b  out  2  (00 rs2, 01 imm, 10 const 4); alu_op  out  2  (00 add, 01 sub/compare, 10 R-funct, 11 I-funct); imm_src  out  2  (00 I, 01 S, 10 B).
REQ-007 SHALL have ports: state  out  4  current state encoding; retire  out  1  instruction-complete pulse; illegal  out  1  sticky illegal-opcode flag.

Function
REQ-008 SHALL implement states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, ILLEGAL=10; codes 11-15 SHALL go to FETCH next cycle with all strobes 0.
REQ-009 SHALL default every output to 0 in every state unless stated below; outputs are combinational from state, opcode, zero, mem_ready.
REQ-010 FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=10, alu_op=00; when mem_ready=1, ir_write=1 and pc_write=1 same cycle, next DECODE; else remain FETCH.
REQ-011 DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, alu_op=00 (branch target to ALUOut); next by opcode: 0000011/0100011 -> MEM_ADDR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1100011 -> BRANCH, other -> ILLEGAL.
REQ-012 MEM_ADDR: alu_src_a=10, alu_src_b=01, alu_op=00, imm_src=00 for load, 01 for store; next MEM_READ (load) or MEM_WRITE (store).
REQ-013 MEM_READ: mem_read=1, iord=1; remain until mem_ready=1, then MEM_WB.
REQ-014 MEM_WB: reg_write=1, mem_to_reg=1, retire=1; next FETCH.
REQ-015 MEM_WRITE: mem_write=1, iord=1; remain until mem_ready=1; on that cycle retire=1, next FETCH.
REQ-016 EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10; next ALU_WB. EXEC_I: alu_src_a=10, alu_src_b=01, imm_src=00, alu_op=11; next ALU_WB.
REQ-017 ALU_WB: reg_write=1, mem_to_reg=0, retire=1; next FETCH.
REQ-018 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero, retire=1; next FETCH.
REQ-019 ILLEGAL: all strobes 0, illegal=1, state held until reset; no further fetch.
REQ-020 mem_read and mem_write SHALL never be 1 together; reg_write and pc_write SHALL never be 1 together.
REQ-021 Minimum latency with mem_ready tied 1: beq 3 cycles, R/I/sw 4, lw 5; each mem_ready=0 cycle in a memory state adds one cycle.
REQ-022 retire SHALL pulse exactly once per completed instruction, never in ILLEGAL.

Reset
REQ-023 On rising clk with rst_n=0, state SHALL load FETCH and illegal SHALL clear, regardless of current state or pending memory access.
REQ-024 While rst_n=0, all outputs except state SHALL be 0 (strobes gated); first fetch begins in the cycle after rst_n returns to 1.
REQ-025 Reset asserted in a waiting memory state SHALL abandon the access; no write strobe after that edge.

Verification
REQ-026 Reset, mem_ready=1, opcode=0110011 -> states 0,1,6,8,0; reg_write=1 only in state 8; retire pulse cycle 4.
REQ-027 opcode=0000011, mem_ready=0 for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0; mem_to_reg=1 in state 4.
REQ-028 opcode=1100011 with zero=1 -> pc_write=1, pc_src=1 in BRANCH; with zero=0 -> pc_write=0; both return to FETCH.
REQ-029 opcode=0100011, mem_ready=1 -> mem_write=1, iord=1 exactly one cycle, imm_src=01 in MEM_ADDR, reg_write never 1.
REQ-030 opcode=1111111 -> ILLEGAL, illegal=1 held 10 cycles, no strobes; rst_n=0 one edge -> state 0, illegal=0.
REQ-031 rst_n=0 during MEM_WRITE wait (mem_ready=0) -> next state FETCH, mem_write=0 from that edge.
